gate_op_arbiter: RTL and testbench

Shares a single WIDTH-bit two-operand bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR) between NREQ requesters. Arbitration is round-robin. Each accepted operation is computed and registered, then held on a single response port until the consumer accepts it. The block sits between request sources (test sequencers, control FSMs) and the shared gate datapath, so that datapath never needs to be replicated per requester.

---
 rtl/gate_op_pkg.sv | 21 ++
 rtl/gate_op_unit.sv | 29 ++
 rtl/gate_op_arbiter.sv | 136 +++++++++++++
 tb/tb_gate_op_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_op_pkg.sv
// Shared types and constants for the round-robin shared gate-op arbiter.
// Opcodes above OP_LAST_LEGAL are reported as errors with a zero result.
package gate_op_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5
    } gate_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [2:0] OP_LAST_LEGAL = 3'd5;

endpackage

// File: rtl/gate_op_unit.sv
// Combinational two-operand bitwise logic unit shared by all requesters.
// Illegal opcodes yield a zero result with err raised.
module gate_op_unit
    import gate_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    always_comb begin
        y   = '0;
        err = (op > OP_LAST_LEGAL);
        case (gate_op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one gate_op_unit among NREQ requesters,
// with a single registered response slot that supports back-to-back issue.
module gate_op_arbiter
    import gate_op_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_err
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             err_q, err_d;

    logic             open_win;
    logic             gnt_any;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] unit_y;
    logic             unit_err;

    // Window is gated by rst_n so req_ready stays low throughout reset.
    always_comb begin
        open_win = rst_n && ((state_q == ST_IDLE) || rsp_ready);
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = '0;
        if (open_win) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cand = IDW'((32'(ptr_q) + i) % 32'(NREQ));
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_op = req_op[3*gnt_idx +: 3];
        sel_a  = req_a[WIDTH*gnt_idx +: WIDTH];
        sel_b  = req_b[WIDTH*gnt_idx +: WIDTH];
    end

    gate_op_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .a   (sel_a),
        .b   (sel_b),
        .op  (sel_op),
        .y   (unit_y),
        .err (unit_err)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;

        if (gnt_any) begin
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    state_d = ST_HOLD;
                    data_d  = unit_y;
                    id_d    = gnt_idx;
                    err_d   = unit_err;
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    if (gnt_any) begin
                        data_d = unit_y;
                        id_d   = gnt_idx;
                        err_d  = unit_err;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == ST_HOLD);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Scoreboard bench for gate_op_arbiter: driver predicts grants and results,
// a separate monitor compares every presented response against the queue.
module tb_gate_op_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_err;

    gate_op_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         id;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_ptr    = 0;
    bit   m_hold   = 1'b0;
    bit   gnt_now  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result table straight from the opcode definitions: {err, data}.
    function automatic logic [8:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            0:       return {1'b0, a & b};
            1:       return {1'b0, a | b};
            2:       return {1'b0, ~(a & b)};
            3:       return {1'b0, ~(a | b)};
            4:       return {1'b0, a ^ b};
            5:       return {1'b0, ~(a ^ b)};
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    task automatic predict_grant();
        int   g;
        bit   open;
        logic [NREQ-1:0] exp_rdy;
        logic [8:0] r;
        exp_t e;
        g       = -1;
        open    = rst_n && (!m_hold || rsp_ready);
        exp_rdy = '0;
        if (open) begin
            for (int i = 0; i < NREQ; i++) begin
                int k;
                k = (m_ptr + i) % NREQ;
                if (g < 0 && req_valid[k]) g = k;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        gnt_now = (g >= 0);
        if (g >= 0) begin
            r      = ref_op(int'(req_op[3*g +: 3]), req_a[8*g +: 8], req_b[8*g +: 8]);
            e.data = r[7:0];
            e.err  = r[8];
            e.id   = g;
            sb.push_back(e);
            m_ptr  = (g + 1) % NREQ;
        end
        if (rst_n) m_hold = (g >= 0) || (m_hold && !rsp_ready);
    endtask

    task automatic tick();
        @(negedge clk);
        predict_grant();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        m_ptr   = 0;
        m_hold  = 1'b0;
        gnt_now = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: peeks the expected head every valid cycle, pops on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                chk("rsp_valid", 32'(rsp_valid), 32'(sb.size() > (gnt_now ? 1 : 0)));
                if (rsp_valid && sb.size() > 0) begin
                    e = sb[0];
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] sweep_tbl [8];
        sweep_tbl = '{8'h48, 8'hDE, 8'hB7, 8'h21, 8'h96, 8'h69, 8'h00, 8'h00};

        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #3;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;

        // Opcode sweep on requester 0, then the two illegal opcodes, then legal again.
        req_a[7:0] = 8'hCA;
        req_b[7:0] = 8'h5C;
        req_valid  = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            int op;
            op          = k % 8;
            req_op[2:0] = 3'(op);
            tick();
            chk("sweep_data", 32'(rsp_data), 32'(sweep_tbl[op]));
            chk("sweep_err", 32'(rsp_err), (op >= 6) ? 32'd1 : 32'd0);
            chk("sweep_id", 32'(rsp_id), 32'd0);
        end
        req_valid = '0;
        tick();

        // Fairness from reset release with everyone requesting.
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) req_op[3*i +: 3] = 3'(i + 1);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("fair_id", 32'(rsp_id), 32'(k % NREQ));
        end
        req_valid = '0;
        tick();

        // Sparse and wrap-around.
        do_reset();
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b1001;
        tick();
        chk("wrap_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        tick();

        // Backpressure: hold a result from requester 0, then 1 and 2 wait.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_id", 32'(rsp_id), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_id", 32'(rsp_id), 32'd1);
        req_valid = '0;
        tick();
        tick();

        // Randomized traffic with random backpressure and illegal opcodes.
        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) req_op[3*i +: 3] = 3'($urandom_range(0, 7));
            req_a     = $urandom;
            req_b     = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("drain_empty", 32'(sb.size()), 32'd0);

        // Reset asserted while a result is held.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        tick();
        chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rsp_data", 32'(rsp_data), 32'd0);
        chk("async_rsp_id", 32'(rsp_id), 32'd0);
        chk("async_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        tick();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        rst_n     = 1'b1;
        tick();
        chk("post_reset_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
